// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared types and constants for the prefetch buffer and its FIFO.
package riscv_fetch_pkg;
  localparam logic [31:0] FETCH_WORD_BYTES = 32'd4;
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} fetch_state_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_fetch_fifo.sv
// riscv_fetch_fifo: DEPTH-entry synchronous FIFO of fetched words with single-cycle flush.
module riscv_fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  assign rdata = mem_q[rd_q];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/riscv_prefetch_buffer.sv
// riscv_prefetch_buffer: word fetcher feeding the instruction aligner through a small FIFO,
// with branch flush and discard of in-flight stale responses.
module riscv_prefetch_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_enable_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  input  logic        hold_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_e state_q, state_d;
  logic [31:0] fetch_addr_q, rsp_addr_q, target;
  logic [OW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty, credit, acc, push, pop, unused_addr_lsb;
  fetch_entry_t head, wentry;
  assign target = {branch_addr_i[31:2], 2'b00};
  assign unused_addr_lsb = ^branch_addr_i[1:0];
  // Stale responses still count against credit, so the FIFO can never overflow.
  assign credit = (32'(fifo_count) + 32'(outstanding_q) < 32'(DEPTH)) &&
                  (32'(outstanding_q) < 32'(MAX_OUTSTANDING));
  assign acc = instr_req_o & instr_gnt_i;
  assign push = instr_rvalid_i & ~branch_i & (state_q != FLUSH);
  assign pop = valid_o & ready_i & ~hold_i & ~branch_i;
  assign outstanding_d = outstanding_q + OW'(acc) - OW'(instr_rvalid_i);
  assign discard_d = branch_i ? outstanding_q - OW'(instr_rvalid_i) :
                     (instr_rvalid_i && discard_q != '0) ? discard_q - OW'(1) : discard_q;
  assign wentry = '{addr: rsp_addr_q, data: instr_rdata_i};
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // FLUSH is held exactly while stale responses remain, so it gates the FIFO write.
  always_comb state_d = (discard_d != '0) ? FLUSH : (fetch_enable_i && credit) ? ISSUE : IDLE;
  always_comb begin
    instr_req_o = ~rst & fetch_enable_i & ~branch_i & credit;
    instr_addr_o = fetch_addr_q;
    busy_o = (outstanding_q != '0) | instr_req_o;
    valid_o = ~fifo_empty;
    rdata_o = head.data;
    addr_o = head.addr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_addr_q <= '0;
      rsp_addr_q <= '0;
      outstanding_q <= '0;
      discard_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q <= discard_d;
      fetch_addr_q <= branch_i ? target : acc ? fetch_addr_q + FETCH_WORD_BYTES : fetch_addr_q;
      rsp_addr_q <= branch_i ? target : push ? rsp_addr_q + FETCH_WORD_BYTES : rsp_addr_q;
    end
  riscv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(branch_i),
    .push(push),
    .pop(pop),
    .wdata(wentry),
    .rdata(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  a_rvalid_owed: assert property (@(posedge clk) disable iff (rst) instr_rvalid_i |-> outstanding_q != '0);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);
  a_max_out: assert property (@(posedge clk) disable iff (rst) 32'(outstanding_q) <= 32'(MAX_OUTSTANDING));
endmodule
